port_scan_ctrl: RTL
===================

Name: port_scan_ctrl

Overview:
- Parametrised ISA port-scan controller. Steps a probe address from BASE_ADDR in STRIDE increments across NUM_PORTS candidate bases.
- For each candidate it issues one probe request to a single shared DSP reset/probe engine and waits for completion or timeout.
- Latches the first responding base address and reports it to the host-side logic.
- Replaces the per-port instantiated sequencers with one probe engine plus this sequencer.

Parameters:
- BASE_ADDR, 16'h0200, first candidate I/O base.
- STRIDE, 16'h0010, address increment between candidates.
- NUM_PORTS, 16, number of candidates; legal range 1..256.
- TIMEOUT_W, 8, width of per-probe timeout counter; timeout fires after 2^TIMEOUT_W-1 cycles.
- CONTINUOUS, 0, 1 = restart the pass after the last candidate with no hit; 0 = stop at DONE.

Ports:
- sys_clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a scan pass from candidate 0.
- abort  in  1  level; forces a return to IDLE.
- probe_req  out  1  request to the probe engine; held high until probe_ack.
- probe_addr  out  16  candidate base; stable while probe_req is high.
- probe_ack  in  1  one-cycle pulse; the probe engine has finished.
- probe_hit  in  1  qualified by probe_ack; 1 = DSP answered 0xAA.
- busy  out  1  high in any state except IDLE and DONE.
- found  out  1  a hit has been latched.
- found_addr  out  16  latched hit base address.
- timeout_err  out  1  sticky; at least one probe timed out this pass.
- done  out  1  one-cycle pulse at the end of a pass.

Behaviour:
Reset values:
- All outputs 0; state IDLE; index 0; timeout counter 0.

States:
- IDLE: start -> ISSUE. On entry to ISSUE: clear found, found_addr, timeout_err; set idx=0.
- ISSUE: probe_req=1, probe_addr=BASE_ADDR+idx*STRIDE (16-bit wrap). Go to WAIT next cycle. probe_req stays high through WAIT.
- WAIT: timeout counter increments each cycle.
  - probe_ack with probe_hit=1 -> FOUND.
  - probe_ack with probe_hit=0 -> NEXT.
  - Counter reaches all-ones with no ack -> set timeout_err, go to NEXT.
  - probe_req drops to 0 in the same cycle as the ack or timeout.
- NEXT: clear the timeout counter.
  - idx < NUM_PORTS-1: idx+1, go to ISSUE.
  - Otherwise: pulse done. CONTINUOUS=1 -> idx=0, go to ISSUE (timeout_err is not cleared on an automatic restart). CONTINUOUS=0 -> DONE.
- FOUND: latch found=1 and found_addr=probe_addr, pulse done, go to DONE.
- DONE: hold outputs; start -> ISSUE with the same clears as from IDLE.

Timing:
- Latency from start to the first probe_req is 1 cycle. Minimum 3 cycles per candidate on an immediate ack.

Boundary rules:
- abort has priority over everything. It drops probe_req the next cycle and goes to IDLE; found and found_addr keep their values; done is not pulsed.
- start while busy is ignored.
- probe_ack outside WAIT is ignored.
- probe_ack in the same cycle the timeout fires: the ack wins and timeout_err is not set.
- NUM_PORTS=1: a single candidate, then done.
- Asynchronous reset mid-probe drops probe_req immediately.

Optional Feature:
- Macro: PORT_SCAN_HIT_MAP_EN.
- Defined:
  - Adds output hit_map [NUM_PORTS-1:0]; bit idx is set on probe_ack with probe_hit for that candidate.
  - A hit does not stop the scan. found and found_addr latch only the first hit.
  - done pulses after the last candidate.
  - hit_map clears on the same events that clear found.
- Undefined: no hit_map port; the scan stops at the first hit as described above.

Test Plan:
- Defaults. start; engine acks a miss on 0x200..0x210 and a hit on 0x220 -> probe_addr sequence 0x200, 0x210, 0x220; found=1, found_addr=0x0220, done pulses once, busy falls.
- No ack ever (TIMEOUT_W=4) -> each probe times out after 15 cycles; timeout_err=1; done after 16 candidates; found=0; probe_addr reached 0x02F0.
- abort asserted in WAIT on candidate 5 (0x250) -> probe_req low the next cycle, state IDLE, no done pulse; a later start rescans from 0x200.
- CONTINUOUS=1, all misses -> after 0x2F0 the next probe_addr is 0x200, with one done pulse per wrap.
- probe_ack+hit in the same cycle the timeout expires on 0x230 -> found_addr=0x0230, timeout_err=0.
- PORT_SCAN_HIT_MAP_EN, hits at 0x220 and 0x280 -> hit_map=16'h0104, found_addr=0x0220, all 16 candidates probed.

Source files
------------

// File: rtl/port_scan_ctrl_if.sv
// Probe-engine bus between the port-scan sequencer (master) and the shared DSP
// reset/probe engine (slave).
interface port_scan_ctrl_if;
    logic        probe_req;
    logic [15:0] probe_addr;
    logic        probe_ack;
    logic        probe_hit;

    modport master (
        output probe_req,
        output probe_addr,
        input  probe_ack,
        input  probe_hit
    );

    modport slave (
        input  probe_req,
        input  probe_addr,
        output probe_ack,
        output probe_hit
    );
endinterface

// File: rtl/port_scan_ctrl.sv
// ISA port-scan sequencer: walks candidate I/O bases through one shared probe engine.
// Optional PORT_SCAN_HIT_MAP_EN: keep scanning after hits and report a per-candidate hit_map_o.
module port_scan_ctrl #(
    parameter logic [15:0] BASE_ADDR  = 16'h0200,
    parameter logic [15:0] STRIDE     = 16'h0010,
    parameter int          NUM_PORTS  = 16,
    parameter int          TIMEOUT_W  = 8,
    parameter int          CONTINUOUS = 0
) (
    input  logic                 sys_clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    port_scan_ctrl_if.master     probe_bus,
    output logic                 busy_o,
    output logic                 found_o,
    output logic [15:0]          found_addr_o,
    output logic                 timeout_err_o,
    output logic                 done_o
`ifdef PORT_SCAN_HIT_MAP_EN
    ,
    output logic [NUM_PORTS-1:0] hit_map_o
`endif
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_PORTS - 1);
    // WAIT lasts 2^TIMEOUT_W-1 cycles: the last one is where the counter would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FOUND,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [15:0]          addr_q, addr_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 found_q, found_d;
    logic [15:0]          found_addr_q, found_addr_d;
    logic                 terr_q, terr_d;
    logic                 req;
    logic                 done;
    logic                 begin_pass;
`ifdef PORT_SCAN_HIT_MAP_EN
    logic [NUM_PORTS-1:0] hit_map_q, hit_map_d;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        tmo_d        = tmo_q;
        found_d      = found_q;
        found_addr_d = found_addr_q;
        terr_d       = terr_q;
        req          = 1'b0;
        done         = 1'b0;
        begin_pass   = 1'b0;
`ifdef PORT_SCAN_HIT_MAP_EN
        hit_map_d    = hit_map_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                begin_pass = start_i;
            end
            S_ISSUE: begin
                req     = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (probe_bus.probe_ack) begin
`ifdef PORT_SCAN_HIT_MAP_EN
                    if (probe_bus.probe_hit) begin
                        hit_map_d[idx_q] = 1'b1;
                        if (!found_q) begin
                            found_d      = 1'b1;
                            found_addr_d = addr_q;
                        end
                    end
                    state_d = S_NEXT;
`else
                    state_d = probe_bus.probe_hit ? S_FOUND : S_NEXT;
`endif
                end else if (tmo_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    req = 1'b1;
                end
            end
            S_NEXT: begin
                tmo_d = '0;
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    addr_d  = addr_q + STRIDE;
                    state_d = S_ISSUE;
                end else begin
                    done = 1'b1;
                    // An automatic restart keeps timeout_err so the host still sees it.
                    if ((CONTINUOUS != 0) && !found_q) begin
                        idx_d   = '0;
                        addr_d  = BASE_ADDR;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FOUND: begin
                found_d      = 1'b1;
                found_addr_d = addr_q;
                done         = 1'b1;
                state_d      = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (begin_pass) begin
            state_d      = S_ISSUE;
            idx_d        = '0;
            addr_d       = BASE_ADDR;
            tmo_d        = '0;
            found_d      = 1'b0;
            found_addr_d = '0;
            terr_d       = 1'b0;
`ifdef PORT_SCAN_HIT_MAP_EN
            hit_map_d    = '0;
`endif
        end

        // Abort overrides everything but leaves the host-visible results untouched.
        if (abort_i) begin
            state_d      = S_IDLE;
            tmo_d        = '0;
            done         = 1'b0;
            found_d      = found_q;
            found_addr_d = found_addr_q;
            terr_d       = terr_q;
`ifdef PORT_SCAN_HIT_MAP_EN
            hit_map_d    = hit_map_q;
`endif
        end
    end

    always_ff @(posedge sys_clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            tmo_q        <= '0;
            found_q      <= 1'b0;
            found_addr_q <= '0;
            terr_q       <= 1'b0;
`ifdef PORT_SCAN_HIT_MAP_EN
            hit_map_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            tmo_q        <= tmo_d;
            found_q      <= found_d;
            found_addr_q <= found_addr_d;
            terr_q       <= terr_d;
`ifdef PORT_SCAN_HIT_MAP_EN
            hit_map_q    <= hit_map_d;
`endif
        end
    end

    assign probe_bus.probe_req  = req;
    assign probe_bus.probe_addr = addr_q;
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign found_o       = found_q;
    assign found_addr_o  = found_addr_q;
    assign timeout_err_o = terr_q;
    assign done_o        = done;
`ifdef PORT_SCAN_HIT_MAP_EN
    assign hit_map_o     = hit_map_q;
`endif

endmodule
